cnn_dot_sequencer: RTL and testbench
====================================

# cnn_dot_sequencer

Sequences the single-port CNN weight memory for a signed dot product. It streams `length` consecutive weights starting at `base_addr`, multiplies each with an activation word taken over a valid/ready handshake, and accumulates the products. It then presents a saturated 32-bit result with a one-cycle `done` pulse. It sits between the CPU custom-instruction interface (start/result) and `weight_memory`, which has a 1-cycle synchronous read, and it is the sole driver of that memory's address.

## Interface
- `DATA_WIDTH`, 32: weight, activation and result width.
- `ADDR_WIDTH`, 10: weight memory address width.
- `ACC_WIDTH`, 64: accumulator width; must be ≥ 2*DATA_WIDTH.

Clock and reset: one clock; reset is synchronous and active-high.

- `clk`  in  1  clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  begin a job; sampled only in IDLE.
- `abort`  in  1  cancel the job in progress.
- `base_addr`  in  ADDR_WIDTH  first weight address; sampled with `start`.
- `length`  in  ADDR_WIDTH+1  element count, 0 allowed; sampled with `start`.
- `act_valid`  in  1  activation word valid.
- `act_data`  in  DATA_WIDTH  signed activation.
- `act_ready`  out  1  sequencer accepts an activation this cycle.
- `w_addr`  out  ADDR_WIDTH  combinational address to `weight_memory`.
- `w_data`  in  DATA_WIDTH  signed weight; equals mem[`w_addr` of the previous cycle].
- `busy`  out  1  job in progress.
- `done`  out  1  one-cycle completion pulse.
- `result`  out  DATA_WIDTH  saturated accumulator; held until the next accepted start.
- `overflow`  out  1  `result` was saturated; held with `result`.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE → RUN when `start`=1 and `length`≠0.
  - `base_q` ← `base_addr`; `len_q` ← `length`; `idx` ← 0; `acc` ← 0.
- IDLE → DONE when `start`=1 and `length`=0.
  - `acc` ← 0. No memory read is consumed and no activation is taken.
- RUN:
  - `act_ready`=1 and `busy`=1.
  - `fire` = `act_valid` & `act_ready`.
  - On `fire`: `acc` ← `acc` + sext(`w_data`)*sext(`act_data`), computed as a full 2*DATA_WIDTH signed product. `acc` wraps modulo 2^ACC_WIDTH. `idx` ← `idx`+1.
  - On `fire` with `idx` = `len_q`−1: go to DONE.
- DONE:
  - `done`=1 for exactly one cycle.
  - `result`/`overflow` were loaded on the edge entering DONE, from the final `acc` value.
  - DONE → IDLE unconditionally.
  - `start` is ignored in DONE.
- Saturation: if `acc` > 2^(DATA_WIDTH−1)−1, `result` = 0x7FFFFFFF and `overflow`=1. If `acc` < −2^(DATA_WIDTH−1), `result` = 0x80000000 and `overflow`=1. Otherwise `result` = `acc`[DATA_WIDTH−1:0] and `overflow`=0.
- `w_addr`:
  - IDLE: `w_addr` = `base_addr`, so the weight is primed on the start cycle.
  - RUN: `w_addr` = `base_q` + `idx` + `fire`, computed modulo 2^ADDR_WIDTH. Addresses wrap, e.g. 1023 → 0.
  - DONE: `w_addr` = `base_q`.
- Stall: when `act_valid`=0 in RUN, `w_addr` holds, so `w_data` stays valid for element `idx`. There is no bubble on resume.
- `abort` in RUN:
  - Go to IDLE on the next edge with no `done` pulse.
  - `result`/`overflow` are unchanged.
  - `abort` takes priority over a simultaneous final `fire`; that final product is discarded.
  - `abort` in IDLE or DONE has no effect.
- `start` while `busy` is ignored; it is not queued.

## Timing
- Reset values: state IDLE, `busy` 0, `done` 0, `act_ready` 0, `result` 0, `overflow` 0, `acc` 0, `idx` 0. `w_addr` = `base_addr` (combinational).
- `reset` mid-RUN: all of the above take effect on the next edge, with no `done`.
- Latency (start accepted at cycle t0, no stalls):
  - fires occur at t1..t(length);
  - `done` is at t(length)+1;
  - `busy` is high t1..t(length)+1.
- Length 0: `done` at t1; `busy` high at t1 only.
- Throughput: one element per cycle; each activation stall adds one cycle.
- Earliest restart: the next `start` is accepted in the first IDLE cycle after DONE, i.e. one job every length+2 cycles.

## Structure
- Package `cnn_pkg` holds:
  - `seq_state_t` enum {IDLE, RUN, DONE};
  - default widths `CNN_DATA_W`=32, `CNN_ADDR_W`=10, `CNN_ACC_W`=64;
  - a saturation function `sat_to_data`.
- Sub-module `cnn_mac`: signed multiply-accumulate with inputs `clr` and `en`, a DATA_WIDTH×DATA_WIDTH product, and an ACC_WIDTH accumulator.
- FSM, address generation and saturation stay in `cnn_dot_sequencer`.

## Test plan
- Basic dot product: base=0, length=4, mem[0..3]=1,2,3,4, act=5,6,7,8 with `act_valid` held high → `w_addr` 0,1,2,3 at t0..t3; `done` at t5; `result`=70; `overflow`=0.
- Stalls: same job with `act_valid` toggling 1,0,1,0… → `w_addr` holds during each stall; `result`=70; `done` at t8.
- Zero length and wrap:
  - length=0 → `done` at t1, `result`=0, `act_ready` never 1.
  - base=1022, length=4 → reads addresses 1022,1023,0,1.
- Saturation: length=2, weights 0x7FFFFFFF, acts 0x7FFFFFFF → `result`=0x7FFFFFFF, `overflow`=1. Weights 0x80000000, acts 0x7FFFFFFF → `result`=0x80000000, `overflow`=1.
- Abort and restart:
  - `abort` after 2 of 4 fires → IDLE next cycle, no `done`, `result` keeps its previous value (70).
  - A `start` asserted while `busy` is ignored.
- Reset: `reset` asserted mid-RUN → next cycle `busy`/`done`/`act_ready`/`result`/`overflow` = 0; a new start then completes normally.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared state type, default widths and the accumulator saturation helper
// for the CNN dot-product sequencer.
package cnn_pkg;

    localparam int unsigned CNN_DATA_W = 32;
    localparam int unsigned CNN_ADDR_W = 10;
    localparam int unsigned CNN_ACC_W  = 64;
    // Widest accumulator sat_to_data can handle; callers sign-extend into it.
    localparam int unsigned CNN_SAT_W  = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    // Clamp acc into the signed data_w range; in-range values come back unchanged,
    // so a caller can detect saturation by comparing the result with the input.
    function automatic logic signed [CNN_SAT_W-1:0] sat_to_data(
        input logic signed [CNN_SAT_W-1:0] acc,
        input int unsigned                 data_w
    );
        logic signed [CNN_SAT_W-1:0] one;
        logic signed [CNN_SAT_W-1:0] max_pos;
        logic signed [CNN_SAT_W-1:0] min_neg;
        one     = CNN_SAT_W'(1);
        max_pos = (one <<< (data_w - 1)) - one;
        min_neg = -max_pos - one;
        if (acc > max_pos) begin
            return max_pos;
        end
        if (acc < min_neg) begin
            return min_neg;
        end
        return acc;
    endfunction

endpackage

// File: rtl/cnn_mac.sv
// Signed multiply-accumulate: one DATA_WIDTH x DATA_WIDTH product per enabled
// cycle into a wrapping ACC_WIDTH accumulator.
module cnn_mac
    import cnn_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = CNN_DATA_W,
    parameter int unsigned ACC_WIDTH  = CNN_ACC_W
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clr,
    input  logic                         en,
    input  logic signed [DATA_WIDTH-1:0] a,
    input  logic signed [DATA_WIDTH-1:0] b,
    output logic signed [ACC_WIDTH-1:0]  acc_next
);

    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0]    acc_q;

    always_comb begin
        prod     = (2*DATA_WIDTH)'(a) * (2*DATA_WIDTH)'(b);
        acc_next = acc_q;
        if (clr) begin
            acc_next = '0;
        end else if (en) begin
            acc_next = acc_q + ACC_WIDTH'(prod);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_next;
        end
    end

endmodule

// File: rtl/cnn_dot_sequencer.sv
// Streams weights from a 1-cycle-latency memory against handshaked activations
// and reports the saturated signed dot product with a one-cycle done pulse.
module cnn_dot_sequencer
    import cnn_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = CNN_DATA_W,
    parameter int unsigned ADDR_WIDTH = CNN_ADDR_W,
    parameter int unsigned ACC_WIDTH  = CNN_ACC_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    input  logic                  act_valid,
    input  logic [DATA_WIDTH-1:0] act_data,
    output logic                  act_ready,
    output logic [ADDR_WIDTH-1:0] w_addr,
    input  logic [DATA_WIDTH-1:0] w_data,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  overflow
);

    seq_state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]       base_q;
    logic [ADDR_WIDTH:0]         len_q;
    logic [ADDR_WIDTH:0]         idx_q;
    logic [DATA_WIDTH-1:0]       result_q;
    logic                        overflow_q;
    logic                        fire;
    logic                        last;
    logic                        mac_clr;
    logic                        mac_en;
    logic signed [ACC_WIDTH-1:0] acc_next;
    logic signed [CNN_SAT_W-1:0] acc_ext;
    logic signed [CNN_SAT_W-1:0] sat_full;

    assign act_ready = (state_q == RUN);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign result    = result_q;
    assign overflow  = overflow_q;
    assign fire      = act_valid & act_ready;
    assign last      = (idx_q == len_q - (ADDR_WIDTH + 1)'(1));
    assign acc_ext   = CNN_SAT_W'(acc_next);
    assign sat_full  = sat_to_data(acc_ext, DATA_WIDTH);

    cnn_mac #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_mac (
        .clk      (clk),
        .reset    (reset),
        .clr      (mac_clr),
        .en       (mac_en),
        .a        (w_data),
        .b        (act_data),
        .acc_next (acc_next)
    );

    always_comb begin
        state_d = state_q;
        mac_clr = 1'b0;
        mac_en  = 1'b0;
        w_addr  = base_q;
        case (state_q)
            IDLE: begin
                // Present base_addr straight away so w_data is primed on the first RUN cycle.
                w_addr = base_addr;
                if (start) begin
                    mac_clr = 1'b1;
                    state_d = (length == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                w_addr = base_q + idx_q[ADDR_WIDTH-1:0] + ADDR_WIDTH'(fire);
                if (abort) begin
                    state_d = IDLE;
                end else if (fire) begin
                    mac_en = 1'b1;
                    if (last) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            base_q     <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            result_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && start) begin
                base_q <= base_addr;
                len_q  <= length;
                idx_q  <= '0;
            end else if (mac_en) begin
                idx_q <= idx_q + (ADDR_WIDTH + 1)'(1);
            end
            if (state_d == DONE && state_q != DONE) begin
                result_q   <= sat_full[DATA_WIDTH-1:0];
                overflow_q <= (sat_full != acc_ext);
            end
        end
    end

endmodule

// File: tb/tb_cnn_dot_sequencer.sv
// Directed self-checking bench for cnn_dot_sequencer with a behavioural
// 1-cycle synchronous weight memory.
module tb_cnn_dot_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic        abort;
    logic [9:0]  base_addr;
    logic [10:0] length;
    logic        act_valid;
    logic [31:0] act_data;
    logic        act_ready;
    logic [9:0]  w_addr;
    logic [31:0] w_data;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        overflow;

    logic [31:0] mem [1024];
    logic [31:0] act_vec [8];

    int          n_checks;
    int          n_fail;

    // Observations recorded by run_job
    int          done_cyc;
    int          done_cnt;
    int          busy_cnt;
    logic        ready_seen;
    logic        busy_after_abort;
    logic [9:0]  addr_log [$];
    logic [9:0]  stall_log [$];

    cnn_dot_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .base_addr (base_addr),
        .length    (length),
        .act_valid (act_valid),
        .act_data  (act_data),
        .act_ready (act_ready),
        .w_addr    (w_addr),
        .w_data    (w_data),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) w_data <= mem[w_addr];

    // Drives one job from its start cycle (t0); inputs change on negedges and
    // outputs are sampled 1 time unit later.
    task automatic run_job(input logic [9:0] b, input logic [10:0] l, input bit toggle,
                           input int abort_after, input int restart_cyc);
        int fires;
        int abort_cyc;
        fires = 0;
        abort_cyc = -1;
        done_cyc = -1;
        done_cnt = 0;
        busy_cnt = 0;
        ready_seen = 1'b0;
        busy_after_abort = 1'b1;
        addr_log.delete();
        stall_log.delete();
        @(negedge clk);
        base_addr = b;
        length = l;
        start = 1'b1;
        abort = 1'b0;
        act_valid = 1'b0;
        #1;
        addr_log.push_back(w_addr);
        for (int cyc = 1; cyc < 64; cyc++) begin
            @(negedge clk);
            start = (cyc == restart_cyc);
            if (start) begin
                length = 11'd0;
                base_addr = 10'd500;
            end
            abort = (abort_cyc < 0) && (fires == abort_after);
            act_valid = toggle ? (cyc % 2 == 1) : 1'b1;
            act_data = act_vec[fires % 8];
            #1;
            if (abort_cyc >= 0 && cyc == abort_cyc + 1) busy_after_abort = busy;
            if (busy) busy_cnt++;
            if (act_ready) ready_seen = 1'b1;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (act_ready && !act_valid) stall_log.push_back(w_addr);
            if (act_ready && act_valid) begin
                addr_log.push_back(w_addr);
                fires++;
            end
            if (abort) abort_cyc = cyc;
            if (done_cyc >= 0 || (abort_cyc >= 0 && cyc >= abort_cyc + 3)) break;
        end
        start = 1'b0;
        abort = 1'b0;
        act_valid = 1'b0;
    endtask

    task automatic set_acts(input logic [31:0] a0, input logic [31:0] a1,
                            input logic [31:0] a2, input logic [31:0] a3);
        act_vec[0] = a0;
        act_vec[1] = a1;
        act_vec[2] = a2;
        act_vec[3] = a3;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        base_addr = 10'd5;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        n_checks++;
        if (act_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_act_ready got %b want 0", act_ready);
        end
        n_checks++;
        if (result !== 32'd0) begin n_fail++; $display("FAIL reset_result got %h want 0", result); end
        n_checks++;
        if (overflow !== 1'b0) begin
            n_fail++; $display("FAIL reset_overflow got %b want 0", overflow);
        end
        n_checks++;
        if (w_addr !== 10'd5) begin n_fail++; $display("FAIL reset_w_addr got %0d want 5", w_addr); end
        reset = 1'b0;
    endtask

    task automatic test_basic;
        set_acts(32'd5, 32'd6, 32'd7, 32'd8);
        run_job(10'd0, 11'd4, 1'b0, -1, -1);
        n_checks++;
        if (addr_log.size() != 5) begin
            n_fail++; $display("FAIL basic_addr_count got %0d want 5", addr_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (addr_log[i] !== 10'(i)) begin
                    n_fail++; $display("FAIL basic_w_addr[%0d] got %0d want %0d", i, addr_log[i], i);
                end
            end
        end
        n_checks++;
        if (done_cyc != 5) begin n_fail++; $display("FAIL basic_done_cycle got %0d want 5", done_cyc); end
        n_checks++;
        if (busy_cnt != 5) begin n_fail++; $display("FAIL basic_busy_cycles got %0d want 5", busy_cnt); end
        n_checks++;
        if (result !== 32'd70) begin n_fail++; $display("FAIL basic_result got %0d want 70", result); end
        n_checks++;
        if (overflow !== 1'b0) begin
            n_fail++; $display("FAIL basic_overflow got %b want 0", overflow);
        end
    endtask

    task automatic test_stalls;
        set_acts(32'd5, 32'd6, 32'd7, 32'd8);
        run_job(10'd0, 11'd4, 1'b1, -1, -1);
        n_checks++;
        if (done_cyc != 8) begin n_fail++; $display("FAIL stall_done_cycle got %0d want 8", done_cyc); end
        n_checks++;
        if (stall_log.size() != 3) begin
            n_fail++; $display("FAIL stall_count got %0d want 3", stall_log.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (stall_log[i] !== 10'(i + 1)) begin
                    n_fail++;
                    $display("FAIL stall_w_addr[%0d] got %0d want %0d", i, stall_log[i], i + 1);
                end
            end
        end
        n_checks++;
        if (result !== 32'd70) begin n_fail++; $display("FAIL stall_result got %0d want 70", result); end
    endtask

    task automatic test_zero_len_and_wrap;
        run_job(10'd9, 11'd0, 1'b0, -1, -1);
        n_checks++;
        if (done_cyc != 1) begin n_fail++; $display("FAIL zero_done_cycle got %0d want 1", done_cyc); end
        n_checks++;
        if (busy_cnt != 1) begin n_fail++; $display("FAIL zero_busy_cycles got %0d want 1", busy_cnt); end
        n_checks++;
        if (ready_seen !== 1'b0) begin n_fail++; $display("FAIL zero_act_ready got 1 want 0"); end
        n_checks++;
        if (result !== 32'd0) begin n_fail++; $display("FAIL zero_result got %0d want 0", result); end
        // 2*1 + (-3)*2 + 1*3 + 2*4 = 7
        set_acts(32'd1, 32'd2, 32'd3, 32'd4);
        run_job(10'd1022, 11'd4, 1'b0, -1, -1);
        n_checks++;
        if (addr_log.size() != 5) begin
            n_fail++; $display("FAIL wrap_addr_count got %0d want 5", addr_log.size());
        end else begin
            n_checks++;
            if (addr_log[0] !== 10'd1022 || addr_log[1] !== 10'd1023 ||
                addr_log[2] !== 10'd0 || addr_log[3] !== 10'd1) begin
                n_fail++;
                $display("FAIL wrap_w_addr got %0d,%0d,%0d,%0d want 1022,1023,0,1",
                         addr_log[0], addr_log[1], addr_log[2], addr_log[3]);
            end
        end
        n_checks++;
        if (result !== 32'd7) begin n_fail++; $display("FAIL wrap_result got %0d want 7", result); end
    endtask

    task automatic test_saturation;
        set_acts(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'd0, 32'd0);
        run_job(10'd100, 11'd2, 1'b0, -1, -1);
        n_checks++;
        if (result !== 32'h7FFF_FFFF || overflow !== 1'b1) begin
            n_fail++; $display("FAIL sat_pos got %h/%b want 7fffffff/1", result, overflow);
        end
        run_job(10'd200, 11'd2, 1'b0, -1, -1);
        n_checks++;
        if (result !== 32'h8000_0000 || overflow !== 1'b1) begin
            n_fail++; $display("FAIL sat_neg got %h/%b want 80000000/1", result, overflow);
        end
        set_acts(32'd1, 32'd0, 32'd0, 32'd0);
        run_job(10'd100, 11'd1, 1'b0, -1, -1);
        n_checks++;
        if (result !== 32'h7FFF_FFFF || overflow !== 1'b0) begin
            n_fail++; $display("FAIL sat_edge_max got %h/%b want 7fffffff/0", result, overflow);
        end
        run_job(10'd200, 11'd1, 1'b0, -1, -1);
        n_checks++;
        if (result !== 32'h8000_0000 || overflow !== 1'b0) begin
            n_fail++; $display("FAIL sat_edge_min got %h/%b want 80000000/0", result, overflow);
        end
        set_acts(32'd3, 32'd0, 32'd0, 32'd0);
        run_job(10'd300, 11'd1, 1'b0, -1, -1);
        n_checks++;
        if (result !== 32'hFFFF_FFEB || overflow !== 1'b0 || done_cyc != 2) begin
            n_fail++;
            $display("FAIL neg_len1 got %h/%b done@%0d want ffffffeb/0 done@2",
                     result, overflow, done_cyc);
        end
    endtask

    task automatic test_abort;
        set_acts(32'd5, 32'd6, 32'd7, 32'd8);
        run_job(10'd0, 11'd4, 1'b0, -1, -1);
        run_job(10'd0, 11'd4, 1'b0, 2, -1);
        n_checks++;
        if (busy_after_abort !== 1'b0) begin n_fail++; $display("FAIL abort_busy got 1 want 0"); end
        n_checks++;
        if (done_cnt != 0) begin n_fail++; $display("FAIL abort_done got %0d want 0", done_cnt); end
        n_checks++;
        if (result !== 32'd70 || overflow !== 1'b0) begin
            n_fail++; $display("FAIL abort_result got %0d/%b want 70/0", result, overflow);
        end
        // abort coincides with the final fire of a 2-element job
        run_job(10'd0, 11'd2, 1'b0, 1, -1);
        n_checks++;
        if (done_cnt != 0 || result !== 32'd70) begin
            n_fail++; $display("FAIL abort_final got done=%0d result=%0d want 0/70", done_cnt, result);
        end
    endtask

    task automatic test_back_to_back;
        set_acts(32'd5, 32'd6, 32'd7, 32'd8);
        run_job(10'd0, 11'd4, 1'b0, -1, 2);
        n_checks++;
        if (done_cyc != 5 || done_cnt != 1 || result !== 32'd70) begin
            n_fail++;
            $display("FAIL busy_start got done@%0d x%0d result=%0d want done@5 x1 70",
                     done_cyc, done_cnt, result);
        end
        // mem[2]*5 + mem[3]*6 = 39, started in the first IDLE cycle after DONE
        run_job(10'd2, 11'd2, 1'b0, -1, -1);
        n_checks++;
        if (done_cyc != 3 || result !== 32'd39) begin
            n_fail++; $display("FAIL restart got done@%0d result=%0d want done@3 39", done_cyc, result);
        end
    endtask

    task automatic test_reset_mid_run;
        set_acts(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'd0, 32'd0);
        run_job(10'd100, 11'd2, 1'b0, -1, -1);
        @(negedge clk);
        base_addr = 10'd0;
        length = 11'd4;
        start = 1'b1;
        act_valid = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        act_valid = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || act_ready !== 1'b0) begin
            n_fail++; $display("FAIL midreset_ctrl got busy=%b done=%b ready=%b want 0/0/0",
                               busy, done, act_ready);
        end
        n_checks++;
        if (result !== 32'd0 || overflow !== 1'b0) begin
            n_fail++; $display("FAIL midreset_result got %h/%b want 0/0", result, overflow);
        end
        set_acts(32'd5, 32'd6, 32'd7, 32'd8);
        run_job(10'd0, 11'd4, 1'b0, -1, -1);
        n_checks++;
        if (done_cyc != 5 || result !== 32'd70) begin
            n_fail++; $display("FAIL midreset_rerun got done@%0d result=%0d want done@5 70",
                               done_cyc, result);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        base_addr = '0;
        length = '0;
        act_valid = 1'b0;
        act_data = '0;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        for (int i = 0; i < 8; i++) act_vec[i] = '0;
        mem[0] = 32'd1;
        mem[1] = 32'd2;
        mem[2] = 32'd3;
        mem[3] = 32'd4;
        mem[1022] = 32'd2;
        mem[1023] = 32'hFFFF_FFFD;
        mem[100] = 32'h7FFF_FFFF;
        mem[101] = 32'h7FFF_FFFF;
        mem[200] = 32'h8000_0000;
        mem[201] = 32'h8000_0000;
        mem[300] = 32'hFFFF_FFF9;
        test_reset();
        test_basic();
        test_stalls();
        test_zero_len_and_wrap();
        test_saturation();
        test_abort();
        test_back_to_back();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
